// File: rtl/axi4_burst_mem_slave_pkg.sv
// AXI4 burst memory slave: shared response/burst codes, FSM states, burst check.
// Optional feature macro: AXI_MEM_WRAP_EN (enables WRAP bursts of len 1/3/7/15).
package axi4_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    // 1 when the burst type/length combination cannot be served.
    function automatic logic burst_bad(input logic [1:0] burst,
                                       input logic [7:0] len);
        logic bad;
        bad = 1'b1;
        unique case (burst)
            BURST_FIXED,
            BURST_INCR: bad = 1'b0;
            BURST_WRAP: begin
`ifdef AXI_MEM_WRAP_EN
                bad = !(len == 8'd1 || len == 8'd3 ||
                        len == 8'd7 || len == 8'd15);
`else
                bad = 1'b1;
`endif
            end
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/axi4_burst_mem_slave_if.sv
// AXI4 slave-side bundle: AW, W, B, AR, R channels.
// Modports: master drives requests/data, slave drives ready/response.
interface axi4_burst_mem_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic [1:0]              awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awregion;
    logic [3:0]              awqos;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic [1:0]              arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arregion;
    logic [3:0]              arqos;
    logic                    arvalid;
    logic                    arready;

    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awlen, awsize, awburst, awlock, awcache,
               awprot, awregion, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arlen, arsize, arburst, arlock, arcache,
               arprot, arregion, arqos, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awlock, awcache,
               awprot, awregion, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arlen, arsize, arburst, arlock, arcache,
               arprot, arregion, arqos, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi4_burst_mem_slave_addr_gen.sv
// AXI4 next-beat address generator (FIXED / INCR / WRAP), purely combinational.
// Ports: addr_i, size_i, len_i, burst_i in; next_o = address of the following beat.
module axi4_burst_addr_gen
    import axi4_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [2:0]            size_i,
    input  logic [7:0]            len_i,
    input  logic [1:0]            burst_i,
    output logic [ADDR_WIDTH-1:0] next_o
);
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] aligned;
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    always_comb begin
        step      = ADDR_WIDTH'(1) << size_i;
        aligned   = addr_i & ~(step - ADDR_WIDTH'(1));
        incr      = aligned + step;
        // Wrap window is (len+1) beats of 2^size bytes.
        wrap_mask = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i)
                    - ADDR_WIDTH'(1);
        next_o    = addr_i;
        unique case (burst_i)
            BURST_INCR: next_o = incr;
            BURST_WRAP: next_o = (aligned & ~wrap_mask) | (incr & wrap_mask);
            default:    next_o = addr_i;
        endcase
    end

endmodule

// File: rtl/axi4_burst_mem_slave.sv
// AXI4 burst memory slave with independent read/write engines and byte strobes.
// Ports: ACLK, ARESETN (async low), S_AXI (slave modport). Macro: AXI_MEM_WRAP_EN.
module axi4_burst_mem_slave
    import axi4_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    axi4_burst_mem_slave_if.slave S_AXI
);
    localparam int STRB_W    = DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(STRB_W);
    localparam int IDX_W     = $clog2(MEM_DEPTH);

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> LANE_BITS) < ADDR_WIDTH'(MEM_DEPTH);
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // ---------------- write engine ----------------
    w_state_t              w_state_q;
    logic                  awready_q, wready_q, bvalid_q;
    logic [1:0]            bresp_q;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [7:0]            wlen_q, wbeat_q;
    logic [2:0]            wsize_q;
    logic [1:0]            wburst_q;
    logic                  wcfg_err_q, werr_q;

    logic                  aw_cfg_err, w_hs, w_last_beat, w_oor;
    logic                  w_we, w_beat_err;
    logic [IDX_W-1:0]      w_idx;

    assign aw_cfg_err  = (S_AXI.awsize > 3'(LANE_BITS)) ||
                         burst_bad(S_AXI.awburst, S_AXI.awlen);
    assign w_hs        = (w_state_q == W_DATA) && wready_q && S_AXI.wvalid;
    assign w_last_beat = (wbeat_q == wlen_q);
    assign w_oor       = !in_range(waddr_q);
    assign w_idx       = IDX_W'(waddr_q >> LANE_BITS);
    // Bad size/burst and out-of-range beats are swallowed without a write.
    assign w_we        = w_hs && !w_oor && !wcfg_err_q;
    assign w_beat_err  = w_oor || wcfg_err_q ||
                         (S_AXI.wlast != w_last_beat);

    axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_wgen (
        .addr_i  (waddr_q),
        .size_i  (wsize_q),
        .len_i   (wlen_q),
        .burst_i (wburst_q),
        .next_o  (waddr_d)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state_q  <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            waddr_q    <= '0;
            wlen_q     <= '0;
            wbeat_q    <= '0;
            wsize_q    <= '0;
            wburst_q   <= '0;
            wcfg_err_q <= 1'b0;
            werr_q     <= 1'b0;
        end else begin
            unique case (w_state_q)
                W_IDLE: begin
                    if (awready_q && S_AXI.awvalid) begin
                        waddr_q    <= S_AXI.awaddr;
                        wlen_q     <= S_AXI.awlen;
                        wsize_q    <= S_AXI.awsize;
                        wburst_q   <= S_AXI.awburst;
                        wbeat_q    <= '0;
                        wcfg_err_q <= aw_cfg_err;
                        werr_q     <= aw_cfg_err;
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b1;
                        w_state_q  <= W_DATA;
                    end else begin
                        awready_q  <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        werr_q  <= werr_q | w_beat_err;
                        waddr_q <= waddr_d;
                        wbeat_q <= wbeat_q + 8'd1;
                        if (w_last_beat) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            bresp_q   <= (werr_q | w_beat_err) ?
                                         RESP_SLVERR : RESP_OKAY;
                            w_state_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI.bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (S_AXI.wstrb[b]) begin
                    mem_q[w_idx][8*b +: 8] <= S_AXI.wdata[8*b +: 8];
                end
            end
        end
    end

    // ---------------- read engine ----------------
    r_state_t              r_state_q;
    logic                  arready_q, rvalid_q, rlast_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic [7:0]            rlen_q, rbeat_q;
    logic [2:0]            rsize_q;
    logic [1:0]            rburst_q;
    logic                  rcfg_err_q;

    // In idle the fetch path looks at AR directly so beat 0 is
    // registered on the handshake edge; afterwards it follows raddr_q.
    logic                  r_idle, ar_cfg_err, r_err;
    logic [ADDR_WIDTH-1:0] r_addr, r_next;
    logic [2:0]            r_size;
    logic [7:0]            r_len;
    logic [1:0]            r_burst;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_word;

    assign r_idle     = (r_state_q == R_IDLE);
    assign ar_cfg_err = (S_AXI.arsize > 3'(LANE_BITS)) ||
                        burst_bad(S_AXI.arburst, S_AXI.arlen);
    assign r_addr     = r_idle ? S_AXI.araddr  : raddr_q;
    assign r_size     = r_idle ? S_AXI.arsize  : rsize_q;
    assign r_len      = r_idle ? S_AXI.arlen   : rlen_q;
    assign r_burst    = r_idle ? S_AXI.arburst : rburst_q;
    assign r_err      = !in_range(r_addr) ||
                        (r_idle ? ar_cfg_err : rcfg_err_q);
    assign r_idx      = IDX_W'(r_addr >> LANE_BITS);
    assign r_word     = r_err ? '0 : mem_q[r_idx];

    axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_rgen (
        .addr_i  (r_addr),
        .size_i  (r_size),
        .len_i   (r_len),
        .burst_i (r_burst),
        .next_o  (r_next)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state_q  <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            raddr_q    <= '0;
            rlen_q     <= '0;
            rbeat_q    <= '0;
            rsize_q    <= '0;
            rburst_q   <= '0;
            rcfg_err_q <= 1'b0;
        end else begin
            unique case (r_state_q)
                R_IDLE: begin
                    if (arready_q && S_AXI.arvalid) begin
                        rlen_q     <= S_AXI.arlen;
                        rsize_q    <= S_AXI.arsize;
                        rburst_q   <= S_AXI.arburst;
                        rcfg_err_q <= ar_cfg_err;
                        raddr_q    <= r_next;
                        rbeat_q    <= '0;
                        rdata_q    <= r_word;
                        rresp_q    <= r_err ? RESP_SLVERR : RESP_OKAY;
                        rlast_q    <= (S_AXI.arlen == 8'd0);
                        rvalid_q   <= 1'b1;
                        arready_q  <= 1'b0;
                        r_state_q  <= R_DATA;
                    end else begin
                        arready_q  <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (S_AXI.rready) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            r_state_q <= R_IDLE;
                        end else begin
                            rbeat_q <= rbeat_q + 8'd1;
                            raddr_q <= r_next;
                            rdata_q <= r_word;
                            rresp_q <= r_err ? RESP_SLVERR : RESP_OKAY;
                            rlast_q <= (rbeat_q + 8'd1 == rlen_q);
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign S_AXI.awready = awready_q;
    assign S_AXI.wready  = wready_q;
    assign S_AXI.bvalid  = bvalid_q;
    assign S_AXI.bresp   = bresp_q;
    assign S_AXI.arready = arready_q;
    assign S_AXI.rvalid  = rvalid_q;
    assign S_AXI.rdata   = rdata_q;
    assign S_AXI.rresp   = rresp_q;
    assign S_AXI.rlast   = rlast_q;

    // Sideband attributes carry no meaning for a plain memory.
    logic unused_attr;
    assign unused_attr = ^{S_AXI.awlock, S_AXI.awcache, S_AXI.awprot,
                           S_AXI.awregion, S_AXI.awqos,
                           S_AXI.arlock, S_AXI.arcache, S_AXI.arprot,
                           S_AXI.arregion, S_AXI.arqos};

endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// Directed bench for axi4_burst_mem_slave: bursts, strobes, range errors, stalls.
// Expected values are hand-derived constants per scenario.
module tb_axi4_burst_mem_slave;
    import axi4_mem_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    logic [31:0] wbuf [16];
    logic [31:0] rd_d [16];
    logic [1:0]  rd_r [16];
    logic        rd_l [16];

    axi4_burst_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_axi ();

    axi4_burst_mem_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_DEPTH  (1024)
    ) dut (
        .ACLK    (clk),
        .ARESETN (rst_n),
        .S_AXI   (s_axi.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic axi_wr(input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [3:0] strb, input bit bad_last,
                          output logic [1:0] resp);
        int t;
        @(negedge clk);
        s_axi.awaddr  = addr;
        s_axi.awlen   = len;
        s_axi.awsize  = size;
        s_axi.awburst = burst;
        s_axi.awvalid = 1'b1;
        t = 0;
        while (!s_axi.awready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("aw_timeout", 64'(t), 0);
        @(negedge clk);
        s_axi.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            s_axi.wdata  = wbuf[i];
            s_axi.wstrb  = strb;
            s_axi.wlast  = bad_last ? 1'b0 : (i == int'(len));
            s_axi.wvalid = 1'b1;
            t = 0;
            while (!s_axi.wready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) chk("w_timeout", 64'(t), 0);
            @(negedge clk);
        end
        s_axi.wvalid = 1'b0;
        s_axi.wlast  = 1'b0;
        s_axi.bready = 1'b1;
        t = 0;
        while (!s_axi.bvalid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("b_timeout", 64'(t), 0);
        resp = s_axi.bresp;
        @(negedge clk);
        s_axi.bready = 1'b0;
    endtask

    task automatic axi_rd(input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input bit toggle, output int n);
        int          t;
        bit          ph;
        bit          stall;
        logic [31:0] sd;
        logic        sl;
        @(negedge clk);
        s_axi.araddr  = addr;
        s_axi.arlen   = len;
        s_axi.arsize  = size;
        s_axi.arburst = burst;
        s_axi.arvalid = 1'b1;
        t = 0;
        while (!s_axi.arready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("ar_timeout", 64'(t), 0);
        @(negedge clk);
        s_axi.arvalid = 1'b0;
        chk("r_latency", 64'(s_axi.rvalid), 1);
        n     = 0;
        t     = 0;
        ph    = 1'b1;
        stall = 1'b0;
        sd    = '0;
        sl    = 1'b0;
        while (n <= int'(len) && t < 200) begin
            s_axi.rready = toggle ? ph : 1'b1;
            ph = ~ph;
            if (stall) begin
                chk("r_stable_data", 64'(s_axi.rdata), 64'(sd));
                chk("r_stable_last", 64'(s_axi.rlast), 64'(sl));
            end
            if (s_axi.rvalid && s_axi.rready) begin
                rd_d[n] = s_axi.rdata;
                rd_r[n] = s_axi.rresp;
                rd_l[n] = s_axi.rlast;
                n++;
                stall = 1'b0;
            end else if (s_axi.rvalid) begin
                stall = 1'b1;
                sd    = s_axi.rdata;
                sl    = s_axi.rlast;
            end else begin
                stall = 1'b0;
            end
            @(negedge clk);
            t++;
        end
        s_axi.rready = 1'b0;
        if (t >= 200) chk("r_timeout", 64'(t), 0);
        chk("r_idle_after", 64'(s_axi.rvalid), 0);
    endtask

    initial begin
        logic [1:0] resp;
        int         n;
        int         nlast;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        s_axi.awaddr = '0;  s_axi.awlen = '0;   s_axi.awsize = '0;
        s_axi.awburst = '0; s_axi.awlock = '0;  s_axi.awcache = '0;
        s_axi.awprot = '0;  s_axi.awregion = '0; s_axi.awqos = '0;
        s_axi.awvalid = 0;  s_axi.wdata = '0;   s_axi.wstrb = '0;
        s_axi.wlast = 0;    s_axi.wvalid = 0;   s_axi.bready = 0;
        s_axi.araddr = '0;  s_axi.arlen = '0;   s_axi.arsize = '0;
        s_axi.arburst = '0; s_axi.arlock = '0;  s_axi.arcache = '0;
        s_axi.arprot = '0;  s_axi.arregion = '0; s_axi.arqos = '0;
        s_axi.arvalid = 0;  s_axi.rready = 0;

        repeat (3) @(negedge clk);
        chk("rst_awready", 64'(s_axi.awready), 0);
        chk("rst_arready", 64'(s_axi.arready), 0);
        chk("rst_wready",  64'(s_axi.wready), 0);
        chk("rst_bvalid",  64'(s_axi.bvalid), 0);
        chk("rst_rvalid",  64'(s_axi.rvalid), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_awready", 64'(s_axi.awready), 1);
        chk("post_rst_arready", 64'(s_axi.arready), 1);

        // INCR 4-beat write then read back
        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        axi_wr(32'h10, 8'd3, 3'd2, BURST_INCR, 4'hF, 1'b0, resp);
        chk("incr_bresp", 64'(resp), 64'(RESP_OKAY));
        axi_rd(32'h10, 8'd3, 3'd2, BURST_INCR, 1'b0, n);
        chk("incr_beats", 64'(n), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("incr_d%0d", i), 64'(rd_d[i]), 64'(i + 1));
            chk($sformatf("incr_r%0d", i), 64'(rd_r[i]), 64'(RESP_OKAY));
            chk($sformatf("incr_l%0d", i), 64'(rd_l[i]), 64'(i == 3));
        end

        // byte strobes
        wbuf[0] = 32'h11223344;
        axi_wr(32'h0, 8'd0, 3'd2, BURST_INCR, 4'hF, 1'b0, resp);
        wbuf[0] = 32'hAABBCCDD;
        axi_wr(32'h0, 8'd0, 3'd2, BURST_INCR, 4'b0101, 1'b0, resp);
        axi_rd(32'h0, 8'd0, 3'd2, BURST_INCR, 1'b0, n);
        chk("strb_data", 64'(rd_d[0]), 64'h11BB33DD);

        // burst running off the end of memory
        wbuf[0] = 32'hDEADBEEF;
        axi_wr(32'hFFC, 8'd0, 3'd2, BURST_INCR, 4'hF, 1'b0, resp);
        chk("top_bresp", 64'(resp), 64'(RESP_OKAY));
        axi_rd(32'hFFC, 8'd3, 3'd2, BURST_INCR, 1'b0, n);
        chk("oor_d0", 64'(rd_d[0]), 64'hDEADBEEF);
        chk("oor_r0", 64'(rd_r[0]), 64'(RESP_OKAY));
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("oor_d%0d", i), 64'(rd_d[i]), 0);
            chk($sformatf("oor_r%0d", i), 64'(rd_r[i]), 64'(RESP_SLVERR));
        end

        // FIXED burst keeps overwriting one word
        wbuf[0] = 32'd5; wbuf[1] = 32'd6; wbuf[2] = 32'd7;
        axi_wr(32'h20, 8'd2, 3'd2, BURST_FIXED, 4'hF, 1'b0, resp);
        chk("fixed_bresp", 64'(resp), 64'(RESP_OKAY));
        axi_rd(32'h20, 8'd0, 3'd2, BURST_INCR, 1'b0, n);
        chk("fixed_data", 64'(rd_d[0]), 7);

        // 8-beat read under rready toggling
        for (int i = 0; i < 8; i++) wbuf[i] = 32'h100 + 32'(i);
        axi_wr(32'h40, 8'd7, 3'd2, BURST_INCR, 4'hF, 1'b0, resp);
        axi_rd(32'h40, 8'd7, 3'd2, BURST_INCR, 1'b1, n);
        chk("stall_beats", 64'(n), 8);
        nlast = 0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("stall_d%0d", i), 64'(rd_d[i]), 64'h100 + 64'(i));
            if (rd_l[i]) nlast++;
        end
        chk("stall_nlast", 64'(nlast), 1);
        chk("stall_last7", 64'(rd_l[7]), 1);

        // WRAP read
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
        axi_wr(32'h30, 8'd3, 3'd2, BURST_INCR, 4'hF, 1'b0, resp);
        axi_rd(32'h38, 8'd3, 3'd2, BURST_WRAP, 1'b0, n);
        chk("wrap_beats", 64'(n), 4);
`ifdef AXI_MEM_WRAP_EN
        chk("wrap_d0", 64'(rd_d[0]), 64'hA2);
        chk("wrap_d1", 64'(rd_d[1]), 64'hA3);
        chk("wrap_d2", 64'(rd_d[2]), 64'hA0);
        chk("wrap_d3", 64'(rd_d[3]), 64'hA1);
        for (int i = 0; i < 4; i++)
            chk($sformatf("wrap_r%0d", i), 64'(rd_r[i]), 64'(RESP_OKAY));
`else
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wrap_d%0d", i), 64'(rd_d[i]), 0);
            chk($sformatf("wrap_r%0d", i), 64'(rd_r[i]), 64'(RESP_SLVERR));
        end
`endif

        // WRAP with an illegal length never writes
        wbuf[0] = 32'hFF; wbuf[1] = 32'hFE; wbuf[2] = 32'hFD;
        axi_wr(32'h30, 8'd2, 3'd2, BURST_WRAP, 4'hF, 1'b0, resp);
        chk("wrap_len_bresp", 64'(resp), 64'(RESP_SLVERR));
        axi_rd(32'h30, 8'd0, 3'd2, BURST_INCR, 1'b0, n);
        chk("wrap_len_nowrite", 64'(rd_d[0]), 64'hA0);

        // oversize transfer
        wbuf[0] = 32'h55;
        axi_wr(32'h30, 8'd0, 3'd3, BURST_INCR, 4'hF, 1'b0, resp);
        chk("size_bresp", 64'(resp), 64'(RESP_SLVERR));
        axi_rd(32'h30, 8'd0, 3'd2, BURST_INCR, 1'b0, n);
        chk("size_nowrite", 64'(rd_d[0]), 64'hA0);

        // wlast missing on final beat
        wbuf[0] = 32'h77; wbuf[1] = 32'h78;
        axi_wr(32'h50, 8'd1, 3'd2, BURST_INCR, 4'hF, 1'b1, resp);
        chk("wlast_bresp", 64'(resp), 64'(RESP_SLVERR));

        // write past end of memory
        wbuf[0] = 32'h12;
        axi_wr(32'h1000, 8'd0, 3'd2, BURST_INCR, 4'hF, 1'b0, resp);
        chk("oor_bresp", 64'(resp), 64'(RESP_SLVERR));

        // error does not leak into the next burst
        wbuf[0] = 32'h99;
        axi_wr(32'h60, 8'd0, 3'd2, BURST_INCR, 4'hF, 1'b0, resp);
        chk("clean_bresp", 64'(resp), 64'(RESP_OKAY));
        axi_rd(32'h60, 8'd0, 3'd2, BURST_INCR, 1'b0, n);
        chk("clean_data", 64'(rd_d[0]), 64'h99);
        chk("clean_rresp", 64'(rd_r[0]), 64'(RESP_OKAY));
        chk("clean_rlast", 64'(rd_l[0]), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
